// File: rtl/wb_line_sram_slave.sv
// Wishbone line responder: one 256-bit line per transfer, moved as four 64-bit beats
// through a single-port word SRAM with byte enables and optional pre-beat wait states.
module wb_line_sram_slave #(
    parameter int ADDR_WIDTH  = 27,
    parameter int DEPTH_LINES = 512,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  CYC,
    input  logic                  STB,
    input  logic                  WE,
    input  logic [ADDR_WIDTH-1:0] ADR,
    input  logic [31:0]           SEL,
    input  logic [255:0]          DAT_M,
    output logic [255:0]          DAT_S,
    output logic                  ACK,
    output logic                  RTY,
    output logic [2:0]            state_dbg
);
    localparam int LW    = $clog2(DEPTH_LINES);
    localparam int WORDS = DEPTH_LINES * 4;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(DEPTH_LINES);
    localparam logic [3:0]            WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [2:0] {IDLE, WAIT, BEAT, LAST, RESP} state_t;

    state_t          state, state_nx;
    logic [1:0]      beat;
    logic [3:0]      wait_cnt;
    logic [LW-1:0]   line_q;
    logic            we_q;
    logic            rty_q;
    logic [31:0]     sel_q;
    logic [255:0]    dat_q;
    logic [191:0]    line_buf;
    logic [63:0]     mem [WORDS];
    logic [63:0]     rdata;
    logic [LW+1:0]   mem_addr;
    logic [63:0]     word_dat;
    logic [7:0]      word_be;
    logic            req;
    logic            in_range;

    assign req       = CYC & STB;
    assign in_range  = (ADR < DEPTH_A);
    assign mem_addr  = {line_q, beat};
    assign word_dat  = dat_q[{beat, 6'd0} +: 64];
    assign word_be   = sel_q[{beat, 3'd0} +: 8];
    assign state_dbg = state;

    // A retry reuses the RESP slot so the request cycle's STB is never re-sampled in IDLE.
    assign ACK = (state == RESP) & ~rty_q & CYC & STB;
    assign RTY = (state == RESP) & rty_q;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (!in_range)            state_nx = RESP;
                    else if (WAIT_CYCLES > 0) state_nx = WAIT;
                    else                      state_nx = BEAT;
                end
            end
            WAIT: if (wait_cnt == 4'd0) state_nx = BEAT;
            BEAT: if (beat == 2'd3) state_nx = we_q ? RESP : LAST;
            LAST: state_nx = RESP;
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= IDLE;
            beat     <= 2'd0;
            wait_cnt <= 4'd0;
            line_q   <= '0;
            we_q     <= 1'b0;
            rty_q    <= 1'b0;
            sel_q    <= '0;
            dat_q    <= '0;
            line_buf <= '0;
            DAT_S    <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        line_q   <= ADR[LW-1:0];
                        we_q     <= WE;
                        sel_q    <= SEL;
                        dat_q    <= DAT_M;
                        rty_q    <= ~in_range;
                        beat     <= 2'd0;
                        wait_cnt <= WAIT_LOAD;
                    end
                end
                WAIT: if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
                BEAT: begin
                    beat <= beat + 2'd1;
                    // rdata holds the word requested on the previous beat.
                    if (!we_q) begin
                        unique case (beat)
                            2'd1:    line_buf[63:0]    <= rdata;
                            2'd2:    line_buf[127:64]  <= rdata;
                            2'd3:    line_buf[191:128] <= rdata;
                            default: ;
                        endcase
                    end
                end
                LAST: DAT_S <= {rdata, line_buf};
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (state == BEAT) begin
            if (we_q) begin
                for (int b = 0; b < 8; b++) begin
                    if (word_be[b]) mem[mem_addr][8*b +: 8] <= word_dat[8*b +: 8];
                end
            end else begin
                rdata <= mem[mem_addr];
            end
        end
    end
endmodule

// File: tb/tb_wb_line_sram_slave.sv
// Bench for wb_line_sram_slave: directed vector table, reset/abort sequences, and
// randomized traffic against a line-level memory model, on WAIT_CYCLES=0 and 3 instances.
module tb_wb_line_sram_slave;
    logic         CLK = 1'b0;
    logic         rst_n;
    logic [1:0]   cyc, stb;
    logic         we;
    logic [26:0]  adr;
    logic [31:0]  sel;
    logic [255:0] dat_m;
    logic [255:0] dat_s0, dat_s3;
    logic [1:0]   ack, rty;
    logic [2:0]   st0, st3;

    always #5 CLK = ~CLK;

    wb_line_sram_slave #(.ADDR_WIDTH(27), .DEPTH_LINES(512), .WAIT_CYCLES(0)) dut0 (
        .CLK(CLK), .RST_N(rst_n), .CYC(cyc[0]), .STB(stb[0]), .WE(we), .ADR(adr),
        .SEL(sel), .DAT_M(dat_m), .DAT_S(dat_s0), .ACK(ack[0]), .RTY(rty[0]), .state_dbg(st0)
    );
    wb_line_sram_slave #(.ADDR_WIDTH(27), .DEPTH_LINES(512), .WAIT_CYCLES(3)) dut3 (
        .CLK(CLK), .RST_N(rst_n), .CYC(cyc[1]), .STB(stb[1]), .WE(we), .ADR(adr),
        .SEL(sel), .DAT_M(dat_m), .DAT_S(dat_s3), .ACK(ack[1]), .RTY(rty[1]), .state_dbg(st3)
    );

    int total = 0;
    int bad = 0;
    logic [255:0] model_mem [2][512];
    bit           valid [2][512];
    logic [255:0] exp_q[$];
    int exp_ack [2];
    int exp_rty [2];
    int ack_cnt [2];
    int rty_cnt [2];
    logic [1:0] prev_ack, prev_rty;

    typedef struct {
        logic         w;
        logic [26:0]  a;
        logic [31:0]  s;
        logic [255:0] dm;
        int           exp_lat;
        logic         exp_rty;
        logic [255:0] exp_dat;
    } vec_t;
    vec_t tbl [11];

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] merge(input logic [255:0] old, input logic [31:0] s,
                                           input logic [255:0] d);
        logic [255:0] r = old;
        for (int b = 0; b < 32; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    // No ACK together with RTY, and neither high two cycles running.
    always @(negedge CLK) begin
        if (!rst_n) begin
            prev_ack = 2'b00;
            prev_rty = 2'b00;
        end else begin
            for (int d = 0; d < 2; d++) begin
                total++;
                if ((ack[d] && rty[d]) || (ack[d] && prev_ack[d]) || (rty[d] && prev_rty[d])) begin
                    bad++;
                    $display("FAIL protocol dut%0d: ack=%b rty=%b prev_ack=%b prev_rty=%b required single pulses",
                             d, ack[d], rty[d], prev_ack[d], prev_rty[d]);
                end
                if (ack[d]) ack_cnt[d]++;
                if (rty[d]) rty_cnt[d]++;
            end
            prev_ack = ack;
            prev_rty = rty;
        end
    end

    // Called just after a rising edge; the request cycle T is the cycle it starts in.
    task automatic do_txn(input int d, input logic w, input logic [26:0] a, input logic [31:0] s,
                          input logic [255:0] dm, output int lat, output logic got_rty,
                          output logic [255:0] rd);
        bit done = 0;
        we = w; adr = a; sel = s; dat_m = dm;
        cyc[d] = 1'b1; stb[d] = 1'b1;
        lat = -1; got_rty = 1'b0; rd = '0;
        for (int n = 1; n <= 40 && !done; n++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (ack[d] || rty[d]) begin
                lat = n;
                got_rty = rty[d];
                rd = (d == 1) ? dat_s3 : dat_s0;
                done = 1;
            end
        end
        @(posedge CLK);
        #1;
        cyc[d] = 1'b0; stb[d] = 1'b0;
    endtask

    task automatic run_op(input int d, input logic w, input logic [26:0] a, input logic [31:0] s,
                          input logic [255:0] dm, input string name, output logic [255:0] rd);
        int wc = (d == 1) ? 3 : 0;
        logic oor = (a >= 27'd512);
        logic [8:0] idx = a[8:0];
        int exp_lat = oor ? 1 : (w ? 5 + wc : 6 + wc);
        int lat;
        logic got_rty;
        logic [255:0] e;
        if (!oor && !w) exp_q.push_back(model_mem[d][idx]);
        do_txn(d, w, a, s, dm, lat, got_rty, rd);
        check_int({name, " latency"}, lat, exp_lat);
        check_int({name, " rty"}, int'(got_rty), int'(oor));
        if (oor) begin
            exp_rty[d]++;
        end else begin
            exp_ack[d]++;
            if (w) begin
                model_mem[d][idx] = merge(model_mem[d][idx], s, dm);
                if (s == 32'hFFFF_FFFF) valid[d][idx] = 1;
            end else begin
                e = exp_q.pop_front();
                check_vec({name, " data"}, rd, e);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] rd;
        logic [255:0] a5 = {4{64'hA5A5_0000_DEAD_BEEF}};
        logic [255:0] pat = {4{64'h0123_4567_89AB_CDEF}};
        logic [255:0] merged = {{24{8'h11}}, 64'hFFFF_FFFF_1111_1111};
        logic [26:0] line;
        logic [26:0] last_line;
        bit seen_ack;

        tbl[0]  = '{1'b1, 27'h10,  32'hFFFF_FFFF, a5,            5, 1'b0, '0};
        tbl[1]  = '{1'b0, 27'h10,  32'h0,         '0,            6, 1'b0, a5};
        tbl[2]  = '{1'b1, 27'h20,  32'hFFFF_FFFF, {32{8'h11}},   5, 1'b0, '0};
        tbl[3]  = '{1'b1, 27'h20,  32'h0000_00F0, {32{8'hFF}},   5, 1'b0, '0};
        tbl[4]  = '{1'b0, 27'h20,  32'h0,         '0,            6, 1'b0, merged};
        tbl[5]  = '{1'b1, 27'h00,  32'hFFFF_FFFF, pat,           5, 1'b0, '0};
        tbl[6]  = '{1'b0, 27'd512, 32'h0,         '0,            1, 1'b1, '0};
        tbl[7]  = '{1'b0, 27'h00,  32'h0,         '0,            6, 1'b0, pat};
        tbl[8]  = '{1'b0, 27'h10,  32'h0,         '0,            6, 1'b0, a5};
        tbl[9]  = '{1'b1, 27'h10,  32'h0,         {32{8'h5A}},   5, 1'b0, '0};
        tbl[10] = '{1'b0, 27'h10,  32'h0,         '0,            6, 1'b0, a5};

        rst_n = 1'b0; cyc = 2'b00; stb = 2'b00;
        we = 1'b0; adr = '0; sel = '0; dat_m = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_int("reset ack0", int'(ack[0]), 0);
        check_int("reset rty0", int'(rty[0]), 0);
        check_vec("reset dat_s0", dat_s0, '0);
        check_int("reset state0", int'(st0), 0);
        check_int("reset ack3", int'(ack[1]), 0);
        check_int("reset state3", int'(st3), 0);
        @(posedge CLK);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            int lat;
            logic got_rty;
            string nm = $sformatf("vec%0d", i);
            do_txn(0, tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].dm, lat, got_rty, rd);
            check_int({nm, " latency"}, lat, tbl[i].exp_lat);
            check_int({nm, " rty"}, int'(got_rty), int'(tbl[i].exp_rty));
            if (tbl[i].exp_rty) exp_rty[0]++;
            else exp_ack[0]++;
            if (!tbl[i].exp_rty && !tbl[i].w) check_vec({nm, " data"}, rd, tbl[i].exp_dat);
            if (!tbl[i].exp_rty && tbl[i].w) begin
                model_mem[0][tbl[i].a[8:0]] = merge(model_mem[0][tbl[i].a[8:0]], tbl[i].s, tbl[i].dm);
                if (tbl[i].s == 32'hFFFF_FFFF) valid[0][tbl[i].a[8:0]] = 1;
            end
        end

        // Read aborted by dropping STB during LAST (cycle T+5): no ACK may appear.
        we = 1'b0; adr = 27'h20; sel = '0; cyc[0] = 1'b1; stb[0] = 1'b1;
        seen_ack = 0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge CLK);
            #1;
            if (n == 5) begin cyc[0] = 1'b0; stb[0] = 1'b0; end
            @(negedge CLK);
            if (ack[0]) seen_ack = 1;
        end
        check_int("abort no ack", int'(seen_ack), 0);
        @(posedge CLK);
        #1;
        run_op(0, 1'b0, 27'h20, '0, '0, "after abort", rd);

        // Reset during beat 1 of a write.
        we = 1'b1; adr = 27'h40; sel = '1; dat_m = rand256(); cyc[0] = 1'b1; stb[0] = 1'b1;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        rst_n = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
        @(posedge CLK);
        #1;
        rst_n = 1'b1;
        @(negedge CLK);
        check_int("midreset ack", int'(ack[0]), 0);
        check_int("midreset rty", int'(rty[0]), 0);
        check_vec("midreset dat_s", dat_s0, '0);
        check_int("midreset state", int'(st0), 0);
        valid[0][9'h40] = 0;
        @(posedge CLK);
        #1;
        run_op(0, 1'b0, 27'h10, '0, '0, "after reset", rd);

        // Wait-state instance.
        run_op(1, 1'b1, 27'h05, 32'hFFFF_FFFF, rand256(), "w3 write", rd);
        run_op(1, 1'b0, 27'h05, '0, '0, "w3 read", rd);
        run_op(1, 1'b1, 27'h05, $urandom(), rand256(), "w3 partial", rd);
        run_op(1, 1'b0, 27'h05, '0, '0, "w3 reread", rd);
        run_op(1, 1'b0, 27'd700, '0, '0, "w3 oor", rd);

        // Back-to-back alternating writes and reads, next request in the cycle after ACK.
        last_line = '0;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                line = 27'($urandom_range(0, 511));
                run_op(0, 1'b1, line, valid[0][line[8:0]] ? $urandom() : 32'hFFFF_FFFF,
                       rand256(), $sformatf("b2b%0d", i), rd);
                last_line = line;
            end else begin
                run_op(0, 1'b0, last_line, '0, '0, $sformatf("b2b%0d", i), rd);
            end
        end

        // Random mix on both instances.
        for (int i = 0; i < 40; i++) begin
            int d = (i % 4 == 3) ? 1 : 0;
            int kind = $urandom_range(0, 9);
            string nm = $sformatf("rand%0d", i);
            line = 27'($urandom_range(0, 511));
            if (kind < 2) begin
                run_op(d, 1'($urandom_range(0, 1)), 27'(512 + $urandom_range(0, 100000)), '0, '0, nm, rd);
            end else if (kind < 6 || !valid[d][line[8:0]]) begin
                run_op(d, 1'b1, line, valid[d][line[8:0]] ? $urandom() : 32'hFFFF_FFFF,
                       rand256(), nm, rd);
            end else begin
                run_op(d, 1'b0, line, '0, '0, nm, rd);
            end
        end

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_int("ack count dut0", ack_cnt[0], exp_ack[0]);
        check_int("ack count dut3", ack_cnt[1], exp_ack[1]);
        check_int("rty count dut0", rty_cnt[0], exp_rty[0]);
        check_int("rty count dut3", rty_cnt[1], exp_rty[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
